// File: rtl/onoff_cmd_gen.sv
// onoff_cmd_gen: valid/ready command driver pulsing j/k into an on/off unit.
// Define ONOFF_RETRY_EN to reissue the pulse up to MAX_RETRY times on timeout.
module onoff_cmd_gen #(
  parameter int TIMEOUT   = 8,
  parameter int MAX_RETRY = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic req_valid,
  input  logic req_on,
  output logic req_ready,
  input  logic status_in,
  output logic j,
  output logic k,
  output logic busy,
  output logic done,
  output logic err,
  input  logic err_clr
);

  localparam int TW = $clog2(TIMEOUT + 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ISSUE = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_DONE  = 3'd3;
  localparam logic [2:0] S_ERR   = 3'd4;

  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);
  localparam logic [TW-1:0] T_MAX  = TW'(TIMEOUT);

  logic [2:0]    state;
  logic [2:0]    nstate;
  logic [TW-1:0] timer;
  logic [TW-1:0] ntimer;
  logic          target;
  logic          ntarget;
  logic          retry_ok;

`ifdef ONOFF_RETRY_EN
  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  logic [RW-1:0] retry;
  logic [RW-1:0] nretry;

  assign retry_ok = (retry < RW'(MAX_RETRY));

  // count is per request, so any return to IDLE starts it fresh
  always_comb begin
    nretry = retry;
    if (nstate == S_IDLE)
      nretry = '0;
    else if (state == S_WAIT && nstate == S_ISSUE)
      nretry = retry + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      retry <= '0;
    else
      retry <= nretry;
  end
`else
  logic unused_max_retry;

  assign unused_max_retry = (MAX_RETRY != 0);
  assign retry_ok = 1'b0;
`endif

  always_comb begin
    nstate  = state;
    ntarget = target;
    ntimer  = timer;
    case (state)
      S_IDLE: begin
        if (req_valid && req_ready) begin
          ntarget = req_on;
          if (status_in == req_on)
            nstate = S_DONE;
          else
            nstate = S_ISSUE;
        end
      end
      S_ISSUE: begin
        ntimer = '0;
        nstate = S_WAIT;
      end
      S_WAIT: begin
        if (timer != T_MAX)
          ntimer = timer + 1'b1;
        // a match wins over a timeout landing in the same cycle
        if (status_in == target)
          nstate = S_DONE;
        else if (timer == T_LAST)
          nstate = retry_ok ? S_ISSUE : S_ERR;
      end
      S_DONE: nstate = S_IDLE;
      S_ERR: begin
        if (err_clr)
          nstate = S_IDLE;
      end
      default: nstate = S_IDLE;
    endcase
  end

  // outputs are registered from the next state so they align with it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      timer     <= '0;
      target    <= 1'b0;
      j         <= 1'b0;
      k         <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      req_ready <= 1'b1;
    end else begin
      state     <= nstate;
      timer     <= ntimer;
      target    <= ntarget;
      j         <= (nstate == S_ISSUE) && ntarget;
      k         <= (nstate == S_ISSUE) && !ntarget;
      busy      <= (nstate != S_IDLE);
      done      <= (nstate == S_DONE);
      err       <= (nstate == S_ERR);
      // one extra dead cycle after DONE spaces requests 3 cycles apart
      req_ready <= (nstate == S_IDLE) && (state != S_DONE);
    end
  end

endmodule

// File: tb/tb_onoff_cmd_gen.sv
// tb_onoff_cmd_gen: random requests against a transaction-level schedule model.
// Expected pulse/done/err cycles are derived per request from the timing rules.
module tb_onoff_cmd_gen;

  localparam int T  = 8;
  localparam int MR = 2;
`ifdef ONOFF_RETRY_EN
  localparam int RETRIES = MR;
`else
  localparam int RETRIES = 0;
`endif
  localparam int NEVER = 1 << 30;

  logic clk       = 1'b0;
  logic rst_n     = 1'b0;
  logic req_valid = 1'b0;
  logic req_on    = 1'b0;
  logic status_in = 1'b0;
  logic err_clr   = 1'b0;
  logic req_ready;
  logic j;
  logic k;
  logic busy;
  logic done;
  logic err;

  int n_chk = 0;
  int n_err = 0;

  onoff_cmd_gen #(
    .TIMEOUT  (T),
    .MAX_RETRY(MR)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_valid(req_valid),
    .req_on   (req_on),
    .req_ready(req_ready),
    .status_in(status_in),
    .j        (j),
    .k        (k),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .err_clr  (err_clr)
  );

  always #5 clk = ~clk;

  // per-request schedule, in cycle numbers counted at negedges
  int   c;
  int   a;
  int   d;
  int   e;
  int   fin;
  int   pv;
  bit   succ;
  bit   no_clr;
  logic tgt;
  int   pulses[$];

  task automatic check(string tag, int got, int exp);
    n_chk++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%0d exp=%0d", tag, c, got, exp);
    end
  endtask

  function automatic bit in_busy(int cc);
    return cc > a && cc <= fin;
  endfunction

  function automatic bit is_pulse(int cc);
    foreach (pulses[i])
      if (pulses[i] == cc)
        return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit in_err(int cc);
    return e >= 0 && cc >= e && cc <= fin;
  endfunction

  function automatic void model_reset();
    a    = -10;
    d    = -10;
    e    = -1;
    fin  = -10;
    succ = 1'b0;
    tgt  = 1'b0;
    pulses.delete();
  endfunction

  // plan a request accepted in cycle a; the unit ignores the first
  // ign pulses and answers the next one lag cycles late
  function automatic void plan(int ign, int lag);
    int p;
    pulses.delete();
    e = -1;
    d = -10;
    if (status_in == tgt) begin
      succ = 1'b1;
      d    = a + 1;
      fin  = d;
    end else begin
      p = a + 1;
      for (int i = 0; i <= RETRIES; i++) begin
        pulses.push_back(p);
        if (i >= ign) begin
          succ = 1'b1;
          d    = p + 2 + lag;
          fin  = d;
          break;
        end
        if (i < RETRIES) begin
          p = p + T + 1;
        end else begin
          succ = 1'b0;
          e    = p + T + 1;
          fin  = NEVER;
        end
      end
    end
  endfunction

  task automatic step(bit force_req, int force_ign);
    bit rdy;
    int ign;
    @(negedge clk);
    c++;
    rdy = !in_busy(c) && !(succ && c == d + 1);
    check("req_ready", req_ready, rdy);
    check("busy", busy, in_busy(c));
    check("j", j, is_pulse(c) && tgt);
    check("k", k, is_pulse(c) && !tgt);
    check("done", done, succ && c == d);
    check("err", err, in_err(c));
    if (in_err(c)) begin
      err_clr = !no_clr && ($urandom_range(0, 3) == 0);
      if (err_clr)
        fin = c;
    end else begin
      err_clr = ($urandom_range(0, 9) == 0);
    end
    if (in_busy(c)) begin
      if (succ && pulses.size() > 0 && c == d - 1)
        status_in = tgt;
    end else if ($urandom_range(0, 4) == 0) begin
      status_in = ~status_in;
    end
    if (force_req) begin
      req_valid = 1'b1;
      req_on    = ~status_in;
    end else begin
      req_valid = ($urandom_range(0, 99) < pv);
      req_on    = 1'($urandom_range(0, 1));
    end
    if (rdy && req_valid) begin
      a   = c;
      tgt = req_on;
      ign = (force_ign >= 0) ? force_ign
                             : $urandom_range(0, RETRIES + 1);
      plan(ign, $urandom_range(0, T - 1));
    end
  endtask

  task automatic accept_now(int ign);
    int n;
    n = 0;
    do begin
      step(1'b1, ign);
      n++;
    end while (a != c && n < 100);
    check("accept_bound", int'(a == c), 1);
  endtask

  task automatic reset_check(string tag);
    #2 rst_n = 1'b0;
    #1;
    check({tag, "_j"}, j, 0);
    check({tag, "_k"}, k, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_err"}, err, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_ready"}, req_ready, 1);
    req_valid = 1'b0;
    err_clr   = 1'b0;
    @(negedge clk);
    c++;
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    int n;
    c      = 0;
    pv     = 60;
    no_clr = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    repeat (2500) step(1'b0, -1);
    pv = 20;
    repeat (1500) step(1'b0, -1);

    for (int r = 0; r < 2; r++) begin
      accept_now(0);
      step(1'b0, -1);
      check("in_issue", int'(c == a + 1), 1);
      reset_check("rst_issue");
      accept_now(0);
      repeat (40) step(1'b0, -1);
    end

    no_clr = 1'b1;
    accept_now(99);
    n = 0;
    do begin
      step(1'b0, -1);
      n++;
    end while (!in_err(c) && n < 100);
    check("err_reach", int'(in_err(c)), 1);
    repeat (5) step(1'b0, -1);
    reset_check("rst_err");
    no_clr = 1'b0;
    accept_now(0);
    repeat (300) step(1'b0, -1);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
